// File: rtl/phase_accumulator_if.sv
// rtl/phase_accumulator_if.sv - increment handshake and ROM address bus for phase_accumulator
//
// Purpose: groups the per-cycle control, increment handshake and address outputs
//          of the phase accumulator so they travel as one bundle.
// Signals:
//   en         master->slave  advance the accumulator this cycle
//   incr       master->slave  requested phase increment (ACC_WIDTH)
//   incr_valid master->slave  incr is valid
//   incr_ready slave->master  a new increment can be accepted
//   addr       slave->master  sine ROM address (ADDRESS_WIDTH)
//   wrap       slave->master  one-cycle pulse, last advance overflowed
//   offset     master->slave  second-channel phase offset (PHASE_OFFSET_EN only)
//   addr2      slave->master  second-channel address (PHASE_OFFSET_EN only)
// Optional feature macro: PHASE_OFFSET_EN
interface phase_accumulator_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int ACC_WIDTH     = 16
);
   logic                     en;
   logic [ACC_WIDTH-1:0]     incr;
   logic                     incr_valid;
   logic                     incr_ready;
   logic [ADDRESS_WIDTH-1:0] addr;
   logic                     wrap;
`ifdef PHASE_OFFSET_EN
   logic [ADDRESS_WIDTH-1:0] offset;
   logic [ADDRESS_WIDTH-1:0] addr2;

   modport master (output en, incr, incr_valid, offset,
                   input  incr_ready, addr, wrap, addr2);
   modport slave  (input  en, incr, incr_valid, offset,
                   output incr_ready, addr, wrap, addr2);
`else
   modport master (output en, incr, incr_valid,
                   input  incr_ready, addr, wrap);
   modport slave  (input  en, incr, incr_valid,
                   output incr_ready, addr, wrap);
`endif
endinterface

// File: rtl/phase_accumulator.sv
// rtl/phase_accumulator.sv - NCO phase accumulator driving the sine ROM address
//
// Purpose: ACC_WIDTH-bit phase accumulator advanced by a programmable increment on
//          each enabled cycle. The top ADDRESS_WIDTH bits address a synchronous sine
//          ROM. New increments arrive over a valid/ready handshake and are applied
//          only at a phase wrap, keeping frequency changes phase-continuous.
// Ports:
//   i_clk  in   single clock, rising edge
//   i_rst  in   synchronous active-high reset
//   bus    slave modport of phase_accumulator_if (en, incr, incr_valid, incr_ready,
//          addr, wrap, and offset/addr2 when PHASE_OFFSET_EN is defined)
// Optional feature macro: PHASE_OFFSET_EN (second, phase-offset address channel)
module phase_accumulator #(
   parameter int                   ADDRESS_WIDTH = 8,
   parameter int                   ACC_WIDTH     = 16,
   parameter logic [ACC_WIDTH-1:0] RESET_INCR    = ACC_WIDTH'(1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   phase_accumulator_if.slave bus
);

   typedef enum logic {
      S_IDLE,
      S_PENDING
   } state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic [ACC_WIDTH-1:0]     r_acc;
   logic [ACC_WIDTH-1:0]     r_incr_active;
   logic [ACC_WIDTH-1:0]     r_incr_pending;
   logic [ACC_WIDTH-1:0]     w_incr_active_next;
   logic [ACC_WIDTH-1:0]     w_incr_pending_next;
   logic                     r_wrap;
   logic [ACC_WIDTH:0]       w_sum;
   logic                     w_carry;
   logic [ACC_WIDTH-1:0]     w_acc_next;
   logic [ADDRESS_WIDTH-1:0] w_addr_next;
   logic                     w_handshake;

   // One extra bit catches the overflow that marks a phase wrap.
   assign w_sum       = {1'b0, r_acc} + {1'b0, r_incr_active};
   assign w_carry     = w_sum[ACC_WIDTH];
   assign w_acc_next  = bus.en ? w_sum[ACC_WIDTH-1:0] : r_acc;
   assign w_addr_next = w_acc_next[ACC_WIDTH-1 -: ADDRESS_WIDTH];
   assign w_handshake = bus.incr_valid & bus.incr_ready;

   always_comb begin
      w_state_next        = r_state;
      w_incr_active_next  = r_incr_active;
      w_incr_pending_next = r_incr_pending;
      case (r_state)
         S_IDLE: begin
            if (w_handshake) begin
               w_incr_pending_next = bus.incr;
               w_state_next        = S_PENDING;
            end
         end
         S_PENDING: begin
            // A zero active increment can never wrap, so the pending value is
            // applied straight away instead of waiting forever.
            if ((r_incr_active == '0) || (bus.en && w_carry)) begin
               w_incr_active_next = r_incr_pending;
               w_state_next       = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= S_IDLE;
         r_acc          <= '0;
         r_incr_active  <= RESET_INCR;
         r_incr_pending <= '0;
         r_wrap         <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_acc          <= w_acc_next;
         r_incr_active  <= w_incr_active_next;
         r_incr_pending <= w_incr_pending_next;
         r_wrap         <= bus.en & w_carry;
      end
   end

   assign bus.addr       = r_acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];
   assign bus.wrap       = r_wrap;
   assign bus.incr_ready = (r_state == S_IDLE) & ~i_rst;

`ifdef PHASE_OFFSET_EN
   logic [ADDRESS_WIDTH-1:0] r_addr2;

   // Built from the next address so addr2 lands on the same edge as addr.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr2 <= '0;
      end else begin
         r_addr2 <= w_addr_next + bus.offset;
      end
   end

   assign bus.addr2 = r_addr2;
`else
   logic w_unused;
   assign w_unused = ^w_addr_next;
`endif

endmodule

// File: tb/tb_phase_accumulator.sv
// tb/tb_phase_accumulator.sv - self-checking bench for phase_accumulator
//
// Purpose: directed scenarios plus randomized traffic, checked against a
//          behavioural model of the accumulator kept in integer arithmetic.
// Optional feature macro: PHASE_OFFSET_EN (enables addr2 checks)
module tb_phase_accumulator;

   localparam int          AW       = 8;
   localparam int          CW       = 16;
   localparam logic [15:0] RST_INCR = 16'h0100;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   phase_accumulator_if #(.ADDRESS_WIDTH(AW), .ACC_WIDTH(CW)) bus ();

   phase_accumulator #(
      .ADDRESS_WIDTH(AW),
      .ACC_WIDTH    (CW),
      .RESET_INCR   (RST_INCR)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: phase as a plain integer, pending increment as a flag+value.
   int m_acc     = 0;
   int m_active  = 0;
   int m_pending = 0;
   bit m_pend    = 1'b0;
   bit m_wrap    = 1'b0;
   int m_addr2   = 0;

   function automatic logic [7:0] e_addr();
      return 8'(m_acc / 256);
   endfunction

   function automatic logic e_ready();
      return !m_pend && !rst;
   endfunction

   // Advance model with the inputs currently driven, then clock the DUT.
   task automatic step();
      int sum;
      bit carry;
      bit apply;
      bit accept;
      if (rst) begin
         m_acc    = 0;
         m_active = int'(RST_INCR);
         m_pend   = 1'b0;
         m_wrap   = 1'b0;
         m_addr2  = 0;
      end else begin
         sum    = m_acc + m_active;
         carry  = (sum >= 65536);
         apply  = m_pend && (m_active == 0 || (bus.en && carry));
         accept = !m_pend && bus.incr_valid;
         if (bus.en) m_acc = sum % 65536;
         m_wrap = bus.en && carry;
         if (apply) begin
            m_active = m_pending;
            m_pend   = 1'b0;
         end
         if (accept) begin
            m_pending = int'(bus.incr);
            m_pend    = 1'b1;
         end
`ifdef PHASE_OFFSET_EN
         m_addr2 = (m_acc / 256 + int'(bus.offset)) % 256;
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_tests++;
      if (bus.addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h exp 00", bus.addr); end
      n_tests++;
      if (bus.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b exp 0", bus.wrap); end
      n_tests++;
      if (bus.incr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst got %b exp 0", bus.incr_ready); end
`ifdef PHASE_OFFSET_EN
      n_tests++;
      if (bus.addr2 !== 8'h00) begin n_fail++; $display("FAIL reset_addr2 got %h exp 00", bus.addr2); end
`endif
      rst = 1'b0;
      #1;
      n_tests++;
      if (bus.incr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %b exp 1", bus.incr_ready); end
   endtask

   task automatic test_sweep();
      int wraps = 0;
      bus.en = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         step();
         if (bus.wrap === 1'b1) wraps++;
         n_tests++;
         if (bus.addr !== 8'(k % 256)) begin n_fail++; $display("FAIL sweep_addr k=%0d got %h exp %h", k, bus.addr, 8'(k % 256)); end
         n_tests++;
         if (bus.wrap !== (k == 256)) begin n_fail++; $display("FAIL sweep_wrap k=%0d got %b exp %b", k, bus.wrap, (k == 256)); end
      end
      n_tests++;
      if (wraps != 1) begin n_fail++; $display("FAIL sweep_wrap_count got %0d exp 1", wraps); end
   endtask

   task automatic test_incr_change();
      int  n;
      bit  seen;
      logic [7:0] prev;
      bus.en = 1'b1;
      seen   = 1'b0;
      for (n = 0; n < 600 && !seen; n++) begin
         step();
         if (bus.addr === 8'h40) seen = 1'b1;
      end
      n_tests++;
      if (!seen) begin n_fail++; $display("FAIL chg_reach_40 got %h exp 40", bus.addr); end
      bus.incr       = 16'h0080;
      bus.incr_valid = 1'b1;
      step();
      bus.incr_valid = 1'b0;
      n_tests++;
      if (bus.incr_ready !== 1'b0) begin n_fail++; $display("FAIL chg_ready_drop got %b exp 0", bus.incr_ready); end
      seen = 1'b0;
      for (n = 0; n < 400 && !seen; n++) begin
         prev = bus.addr;
         step();
         n_tests++;
         if (bus.addr !== 8'(prev + 8'd1)) begin n_fail++; $display("FAIL chg_step1 got %h exp %h", bus.addr, 8'(prev + 8'd1)); end
         if (bus.wrap === 1'b1) seen = 1'b1;
         else begin
            n_tests++;
            if (bus.incr_ready !== 1'b0) begin n_fail++; $display("FAIL chg_ready_held got %b exp 0", bus.incr_ready); end
         end
      end
      n_tests++;
      if (!seen || bus.addr !== 8'h00) begin n_fail++; $display("FAIL chg_wrap_at_00 got %h exp 00", bus.addr); end
      n_tests++;
      if (bus.incr_ready !== 1'b1) begin n_fail++; $display("FAIL chg_ready_rise got %b exp 1", bus.incr_ready); end
      for (int k = 1; k <= 8; k++) begin
         step();
         n_tests++;
         if (bus.addr !== 8'(k / 2)) begin n_fail++; $display("FAIL chg_half_step k=%0d got %h exp %h", k, bus.addr, 8'(k / 2)); end
      end
   endtask

   task automatic test_en_hold();
      bit seen = 1'b0;
      bus.en = 1'b1;
      for (int n = 0; n < 1000 && !seen; n++) begin
         step();
         if (bus.addr === 8'h20) seen = 1'b1;
      end
      n_tests++;
      if (!seen) begin n_fail++; $display("FAIL hold_reach_20 got %h exp 20", bus.addr); end
      bus.en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         n_tests++;
         if (bus.addr !== 8'h20 || bus.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_addr got %h/%b exp 20/0", bus.addr, bus.wrap);
         end
      end
      bus.en = 1'b1;
      step();
      n_tests++;
      if (bus.addr !== e_addr()) begin n_fail++; $display("FAIL hold_resume1 got %h exp %h", bus.addr, e_addr()); end
      step();
      n_tests++;
      if (bus.addr !== 8'h21) begin n_fail++; $display("FAIL hold_resume2 got %h exp 21", bus.addr); end
   endtask

   task automatic test_zero_incr();
      bit seen = 1'b0;
      logic [7:0] prev;
      bus.en         = 1'b1;
      bus.incr       = 16'h0000;
      bus.incr_valid = 1'b1;
      step();
      bus.incr_valid = 1'b0;
      for (int n = 0; n < 1200 && !seen; n++) begin
         step();
         n_tests++;
         if (bus.addr !== e_addr()) begin n_fail++; $display("FAIL zero_run got %h exp %h", bus.addr, e_addr()); end
         if (bus.wrap === 1'b1) seen = 1'b1;
      end
      n_tests++;
      if (!seen) begin n_fail++; $display("FAIL zero_wrap_timeout got %b exp 1", bus.wrap); end
      for (int k = 0; k < 5; k++) begin
         step();
         n_tests++;
         if (bus.addr !== 8'h00) begin n_fail++; $display("FAIL zero_frozen got %h exp 00", bus.addr); end
      end
      bus.en         = 1'b0;
      bus.incr       = 16'h0200;
      bus.incr_valid = 1'b1;
      step();
      bus.incr_valid = 1'b0;
      n_tests++;
      if (bus.incr_ready !== 1'b0) begin n_fail++; $display("FAIL escape_accept got %b exp 0", bus.incr_ready); end
      step();
      n_tests++;
      if (bus.incr_ready !== 1'b1) begin n_fail++; $display("FAIL escape_applied got %b exp 1", bus.incr_ready); end
      bus.en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         prev = bus.addr;
         step();
         n_tests++;
         if (bus.addr !== 8'(prev + 8'd2)) begin n_fail++; $display("FAIL escape_step2 got %h exp %h", bus.addr, 8'(prev + 8'd2)); end
      end
   endtask

   task automatic test_reset_pending();
      bus.en         = 1'b1;
      bus.incr       = 16'h0300;
      bus.incr_valid = 1'b1;
      step();
      bus.incr_valid = 1'b0;
      n_tests++;
      if (bus.incr_ready !== 1'b0) begin n_fail++; $display("FAIL rstp_pending got %b exp 0", bus.incr_ready); end
      rst = 1'b1;
      step();
      step();
      n_tests++;
      if (bus.addr !== 8'h00 || bus.wrap !== 1'b0 || bus.incr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rstp_in_reset got addr=%h wrap=%b ready=%b exp 00/0/0", bus.addr, bus.wrap, bus.incr_ready);
      end
      rst = 1'b0;
      #1;
      n_tests++;
      if (bus.incr_ready !== 1'b1) begin n_fail++; $display("FAIL rstp_ready_after got %b exp 1", bus.incr_ready); end
      for (int k = 1; k <= 40; k++) begin
         step();
         n_tests++;
         if (bus.addr !== 8'(k)) begin n_fail++; $display("FAIL rstp_step1 k=%0d got %h exp %h", k, bus.addr, 8'(k)); end
      end
   endtask

`ifdef PHASE_OFFSET_EN
   task automatic test_offset();
      bus.en     = 1'b1;
      bus.offset = 8'h40;
      for (int k = 0; k < 300; k++) begin
         step();
         n_tests++;
         if (bus.addr2 !== 8'(m_acc / 256 + 64)) begin
            n_fail++;
            $display("FAIL offset_addr2 got %h exp %h", bus.addr2, 8'(m_acc / 256 + 64));
         end
      end
   endtask
`endif

   task automatic test_random();
      for (int k = 0; k < 3000; k++) begin
         rst            = ($urandom_range(0, 99) == 0);
         bus.en         = ($urandom_range(0, 3) != 0);
         bus.incr_valid = ($urandom_range(0, 2) == 0);
         bus.incr       = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h1FFF));
`ifdef PHASE_OFFSET_EN
         if ($urandom_range(0, 9) == 0) bus.offset = 8'($urandom);
`endif
         step();
         n_tests++;
         if (bus.addr !== e_addr() || bus.wrap !== m_wrap || bus.incr_ready !== e_ready()) begin
            n_fail++;
            $display("FAIL rand k=%0d got addr=%h wrap=%b ready=%b exp %h/%b/%b",
                     k, bus.addr, bus.wrap, bus.incr_ready, e_addr(), m_wrap, e_ready());
         end
`ifdef PHASE_OFFSET_EN
         n_tests++;
         if (bus.addr2 !== 8'(m_addr2)) begin n_fail++; $display("FAIL rand_addr2 k=%0d got %h exp %h", k, bus.addr2, 8'(m_addr2)); end
`endif
      end
      rst = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      bus.en         = 1'b0;
      bus.incr       = '0;
      bus.incr_valid = 1'b0;
`ifdef PHASE_OFFSET_EN
      bus.offset     = '0;
`endif
      test_reset();
      test_sweep();
      test_incr_change();
      test_en_hold();
      test_zero_incr();
      test_reset_pending();
`ifdef PHASE_OFFSET_EN
      test_offset();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/phase_accumulator.md
# phase_accumulator

Numerically-controlled address generator for the sine signal generator. Holds an ACC_WIDTH-bit phase accumulator. Each enabled cycle it advances the accumulator by a programmable increment, and it drives the top ADDRESS_WIDTH bits as the lookup address to the downstream synchronous sine ROM. A new increment is accepted through a valid/ready handshake and takes effect only at a phase wrap, so frequency changes are phase-continuous.

## Interface
- ADDRESS_WIDTH, 8: width of the address driven to the sine ROM.
- ACC_WIDTH, 16: accumulator width; must be >= ADDRESS_WIDTH.
- RESET_INCR, 1: increment loaded into the active register on reset.
- clk  in  1: single clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- en  in  1: advance the accumulator this cycle.
- incr  in  ACC_WIDTH: requested phase increment.
- incr_valid  in  1: incr is valid.
- incr_ready  out  1: block can accept a new increment.
- addr  out  ADDRESS_WIDTH: acc[ACC_WIDTH-1 -: ADDRESS_WIDTH], registered.
- wrap  out  1: one-cycle pulse; the last advance overflowed the accumulator.
- offset  in  ADDRESS_WIDTH: phase offset for the second channel (PHASE_OFFSET_EN only).
- addr2  out  ADDRESS_WIDTH: offset-channel address (PHASE_OFFSET_EN only).

## Operation
- Registers:
  - acc
  - incr_active
  - incr_pending
  - state ∈ {IDLE, PENDING}
- Reset (rst=1 at an edge):
  - acc=0, incr_active=RESET_INCR, incr_pending=0, state=IDLE.
  - Outputs: addr=0, wrap=0, addr2=0.
  - incr_ready=0 while rst is high.
- Advance: if en=1, then {carry, acc} <= acc + incr_active. The sum is modulo 2^ACC_WIDTH, and carry is the bit lost above ACC_WIDTH. If en=0, acc holds.
- wrap <= en & carry. It is registered, so it is high in the same cycle that addr first shows the wrapped value. wrap=0 whenever en=0.
- incr_ready = (state==IDLE) & ~rst. This is combinational from state.
- IDLE:
  - A handshake (incr_valid & incr_ready) writes incr_pending <= incr.
  - state -> PENDING.
- PENDING:
  - incr_valid is ignored.
  - At the edge where en & carry, incr_active <= incr_pending and state -> IDLE. The advance on that edge uses the old increment; the next advance uses the new one.
- Stall escape: if state==PENDING and incr_active==0, apply the pending increment at the next edge regardless of en, and return to IDLE. No wrap can ever occur in that case.
- A handshake accepted on the same edge as a wrap does not apply at that wrap. It waits for the following wrap.
- en=0 in PENDING with incr_active≠0: the block stays PENDING indefinitely. This is legal.
- incr=0 is legal and freezes addr once applied.
- Reset mid-PENDING discards incr_pending and restores RESET_INCR.

## Timing
- addr changes on the edge after an enabled cycle; latency en->addr is 1 cycle.
- The downstream ROM adds 1 cycle, so ROM dout corresponds to the addr of the previous cycle.
- Increment change latency: accepted at edge N, effective on the first advance after the next wrap edge.
- incr_ready drops the cycle after acceptance and rises the cycle after the applying edge.
- No combinational path from incr/incr_valid/en to any output.

## Configuration
- PHASE_OFFSET_EN defined:
  - Ports offset and addr2 exist.
  - addr2 <= next_addr + offset, modulo 2^ADDRESS_WIDTH, registered on the same edge as addr, so addr2 is always cycle-aligned with addr.
  - addr2 holds when en=0 and offset is unchanged; otherwise it tracks the new offset on the next edge.
- PHASE_OFFSET_EN undefined: offset and addr2 ports and their logic are absent. All other behaviour is identical.

## Test plan
All scenarios use ADDRESS_WIDTH=8, ACC_WIDTH=16.
- Reset, then RESET_INCR=0x0100 with en=1 for 300 cycles -> addr 1,2,…,255,0; wrap high exactly in the cycle addr=0 (cycle 256); no other wrap pulses.
- Load incr=0x0080 mid-period at addr=0x40 -> incr_ready low for the next cycle onward; step stays 1/cycle through addr=0xFF,0x00 (wrap); thereafter addr advances every 2 cycles (0x00,0x00,0x01,0x01…); incr_ready high again.
- Toggle en=0 for 10 cycles at addr=0x20 -> addr holds 0x20, wrap=0; resumes 0x21 one cycle after en=1.
- Load incr=0 at the next wrap, then offer incr=0x0200 -> accepted; applied one cycle later despite en=0; addr then steps by 2 per enabled cycle.
- Assert rst while PENDING (pending 0x0300) -> addr=0, wrap=0, incr_ready=0 during rst, 1 after; step returns to 1/cycle; 0x0300 never applied.
- PHASE_OFFSET_EN, offset=0x40, incr=0x0100 -> addr2 == (addr+0x40) mod 256 every cycle, e.g. addr=0xC0 gives addr2=0x00.
